// File: rtl/mult_hilo_ctrl_if.sv
// Controller <-> shared Booth multiplier link: registered operands and launch pulse out,
// completion and product back.
interface mult_hilo_ctrl_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0]   booth_a;
  logic [WIDTH-1:0]   booth_b;
  logic               booth_start;
  logic               booth_ready;
  logic [2*WIDTH-1:0] booth_result;

  modport master (
    output booth_a, booth_b, booth_start,
    input  booth_ready, booth_result
  );

  modport slave (
    input  booth_a, booth_b, booth_start,
    output booth_ready, booth_result
  );
endinterface

// File: rtl/mult_hilo_ctrl.sv
// MULT sequencer for the MIPS core: launches the shared Booth multiplier, captures the
// product into HI/LO, serves MFHI/MFLO and stalls the front end while a multiply is in flight.
module mult_hilo_ctrl #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mult_req,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mfhi_req,
  input  logic             mflo_req,
  output logic [WIDTH-1:0] rd_data,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             err,
  mult_hilo_ctrl_if.master booth
);

  localparam int              CW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] a_n, b_n, hi_n, lo_n;
  logic             start_n, done_n, err_n;
  logic             ready_q;
  logic             rdy_rise;

  // Edge-qualified completion: a ready level left high by the previous op must not
  // complete the next one.
  assign rdy_rise = booth.booth_ready & ~ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      cnt               <= '0;
      ready_q           <= 1'b0;
      hi                <= '0;
      lo                <= '0;
      done              <= 1'b0;
      err               <= 1'b0;
      booth.booth_a     <= '0;
      booth.booth_b     <= '0;
      booth.booth_start <= 1'b0;
    end else begin
      state             <= state_n;
      cnt               <= cnt_n;
      ready_q           <= booth.booth_ready;
      hi                <= hi_n;
      lo                <= lo_n;
      done              <= done_n;
      err               <= err_n;
      booth.booth_a     <= a_n;
      booth.booth_b     <= b_n;
      booth.booth_start <= start_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    a_n     = booth.booth_a;
    b_n     = booth.booth_b;
    hi_n    = hi;
    lo_n    = lo;
    start_n = 1'b0;
    done_n  = 1'b0;
    err_n   = err;
    unique case (state)
      IDLE: begin
        if (mult_req) begin
          a_n     = op_a;
          b_n     = op_b;
          start_n = 1'b1;
          state_n = START;
        end
      end
      START: begin
        cnt_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        // Completion takes priority over a timeout landing in the same cycle.
        if (rdy_rise) begin
          hi_n    = booth.booth_result[2*WIDTH-1:WIDTH];
          lo_n    = booth.booth_result[WIDTH-1:0];
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (cnt == CNT_MAX) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign stall   = busy & (mult_req | mfhi_req | mflo_req);
  assign rd_data = mfhi_req ? hi : (mflo_req ? lo : '0);

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Randomized self-checking bench for mult_hilo_ctrl with a behavioural Booth multiplier.
module tb_mult_hilo_ctrl;
  localparam int W  = 16;
  localparam int TO = 24;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mult_req = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         mfhi_req = 1'b0;
  logic         mflo_req = 1'b0;
  logic [W-1:0] rd_data, hi, lo;
  logic         stall, busy, done, err;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mult_hilo_ctrl_if #(.WIDTH(W)) bus ();

  mult_hilo_ctrl #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mult_req (mult_req),
    .op_a     (op_a),
    .op_b     (op_b),
    .mfhi_req (mfhi_req),
    .mflo_req (mflo_req),
    .rd_data  (rd_data),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .booth    (bus)
  );

  // Behavioural multiplier: drops ready on launch, raises it (level) lat edges later.
  bit          model_en = 1'b1;
  int          lat = 5;
  int          m_cnt = 0;
  bit          m_pend = 1'b0;
  logic        m_ready = 1'b0;
  logic [31:0] m_res = '0;
  int          start_cnt = 0;

  assign bus.booth_ready  = m_ready;
  assign bus.booth_result = m_res;

  always @(posedge clk) begin
    if (bus.booth_start === 1'b1) begin
      start_cnt <= start_cnt + 1;
      m_ready   <= 1'b0;
      m_res     <= ref_prod(bus.booth_a, bus.booth_b);
      m_pend    <= model_en;
      m_cnt     <= lat;
    end else if (m_pend) begin
      if (m_cnt <= 1) begin
        m_ready <= 1'b1;
        m_pend  <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b);
    shortint sa, sb;
    int p;
    sa = a;
    sb = b;
    p  = int'(sa) * int'(sb);
    return 32'(p);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    op_a = a;
    op_b = b;
    mult_req = 1'b1;
    tick();
    mult_req = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit seen);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 200) begin
      tick();
      cyc++;
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_chk++;
    if ({hi, lo} !== 32'h0) $display("FAIL reset_hilo: got %h expected 00000000", {hi, lo});
    else n_pass++;
    n_chk++;
    if ({busy, done, err, stall, bus.booth_start} !== 5'b0)
      $display("FAIL reset_flags: busy/done/err/stall/start got %b expected 00000",
               {busy, done, err, stall, bus.booth_start});
    else n_pass++;
    n_chk++;
    if ({bus.booth_a, bus.booth_b, rd_data} !== 48'h0)
      $display("FAIL reset_ops: got %h expected 0", {bus.booth_a, bus.booth_b, rd_data});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    int s0, rise_at, done_at;
    logic prev;
    lat = 17;
    s0 = start_cnt;
    issue(16'd4, 16'd7);
    n_chk++;
    if ({bus.booth_start, busy, bus.booth_a, bus.booth_b} !== {1'b1, 1'b1, 16'd4, 16'd7})
      $display("FAIL basic_launch: start=%b busy=%b a=%h b=%h expected 1 1 0004 0007",
               bus.booth_start, busy, bus.booth_a, bus.booth_b);
    else n_pass++;
    prev = bus.booth_ready;
    rise_at = -1;
    done_at = -1;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (done === 1'b1) begin
        done_at = c;
        break;
      end
      if (bus.booth_ready === 1'b1 && prev !== 1'b1 && rise_at < 0) rise_at = c;
      prev = bus.booth_ready;
    end
    n_chk++;
    if (rise_at < 0 || done_at != rise_at + 1)
      $display("FAIL basic_latency: done at %0d expected %0d", done_at, rise_at + 1);
    else n_pass++;
    n_chk++;
    if ({hi, lo, busy} !== {16'h0000, 16'h001c, 1'b0})
      $display("FAIL basic_result: hi=%h lo=%h busy=%b expected 0000 001c 0", hi, lo, busy);
    else n_pass++;
    tick();
    n_chk++;
    if (done !== 1'b0 || start_cnt - s0 != 1)
      $display("FAIL basic_pulses: done=%b starts=%0d expected 0 1", done, start_cnt - s0);
    else n_pass++;
  endtask

  task automatic test_signed;
    logic [15:0] as[$], bs[$];
    logic [31:0] expv;
    int cyc;
    bit seen;
    as = '{16'h0001, 16'hfff6, 16'h8000, 16'h7fff};
    bs = '{16'hffff, 16'hffff, 16'h8000, 16'h8000};
    for (int i = 0; i < 6; i++) begin
      as.push_back(16'($urandom));
      bs.push_back(16'($urandom));
    end
    for (int i = 0; i < as.size(); i++) begin
      lat = $urandom_range(1, TO - 1);
      expv = ref_prod(as[i], bs[i]);
      issue(as[i], bs[i]);
      wait_done(cyc, seen);
      n_chk++;
      if (!seen || {hi, lo} !== expv)
        $display("FAIL signed_%0d: %h*%h got hi:lo=%h (done=%b) expected %h",
                 i, as[i], bs[i], {hi, lo}, seen, expv);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_back_to_back;
    int s0, bad, cyc;
    bit seen;
    lat = 6;
    s0 = start_cnt;
    bad = 0;
    seen = 1'b0;
    issue(16'd4, 16'd7);
    op_a = 16'd3;
    op_b = 16'd5;
    mult_req = 1'b1;
    #1;
    for (int c = 0; c < 100; c++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (stall !== 1'b1) bad++;
      tick();
    end
    n_chk++;
    if (!seen || bad != 0 || stall !== 1'b0 || lo !== 16'h001c)
      $display("FAIL b2b_first: done=%b stall_gaps=%0d stall=%b lo=%h expected 1 0 0 001c",
               seen, bad, stall, lo);
    else n_pass++;
    tick();
    mult_req = 1'b0;
    n_chk++;
    if (bus.booth_start !== 1'b1 || bus.booth_a !== 16'd3)
      $display("FAIL b2b_accept: start=%b a=%h expected 1 0003", bus.booth_start, bus.booth_a);
    else n_pass++;
    wait_done(cyc, seen);
    n_chk++;
    if (!seen || cyc != lat + 2)
      $display("FAIL b2b_latency: done after %0d cycles expected %0d", cyc, lat + 2);
    else n_pass++;
    n_chk++;
    if ({hi, lo} !== 32'h0000_000f || start_cnt - s0 != 2)
      $display("FAIL b2b_result: hi:lo=%h starts=%0d expected 0000000f 2", {hi, lo}, start_cnt - s0);
    else n_pass++;
    tick();
  endtask

  task automatic test_mflo_stall;
    int bad;
    bit seen;
    lat = 9;
    bad = 0;
    seen = 1'b0;
    issue(16'd4, 16'd7);
    mflo_req = 1'b1;
    #1;
    for (int c = 0; c < 100; c++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (stall !== 1'b1) bad++;
      tick();
    end
    n_chk++;
    if (!seen || bad != 0)
      $display("FAIL mflo_stall: done=%b stall_gaps=%0d expected 1 0", seen, bad);
    else n_pass++;
    n_chk++;
    if (stall !== 1'b0 || rd_data !== 16'h001c)
      $display("FAIL mflo_read: stall=%b rd_data=%h expected 0 001c", stall, rd_data);
    else n_pass++;
    mflo_req = 1'b0;
    tick();
  endtask

  task automatic test_idle_read;
    int cyc;
    bit seen;
    lat = 4;
    issue(16'h0100, 16'h0300);
    wait_done(cyc, seen);
    tick();
    mfhi_req = 1'b1;
    mflo_req = 1'b1;
    #1;
    n_chk++;
    if (rd_data !== 16'h0003 || stall !== 1'b0)
      $display("FAIL idle_both: rd_data=%h stall=%b expected 0003 0", rd_data, stall);
    else n_pass++;
    mfhi_req = 1'b0;
    #1;
    n_chk++;
    if (rd_data !== 16'h0000) $display("FAIL idle_mflo: rd_data=%h expected 0000", rd_data);
    else n_pass++;
    mflo_req = 1'b0;
    mfhi_req = 1'b1;
    op_a = 16'd2;
    op_b = 16'd2;
    mult_req = 1'b1;
    #1;
    n_chk++;
    if (rd_data !== 16'h0003 || stall !== 1'b0)
      $display("FAIL idle_mult_read: rd_data=%h stall=%b expected 0003 0", rd_data, stall);
    else n_pass++;
    tick();
    mult_req = 1'b0;
    #1;
    n_chk++;
    if (stall !== 1'b1) $display("FAIL idle_then_stall: stall=%b expected 1", stall);
    else n_pass++;
    wait_done(cyc, seen);
    n_chk++;
    if (!seen || rd_data !== 16'h0000 || lo !== 16'h0004)
      $display("FAIL idle_new: done=%b rd_data=%h lo=%h expected 1 0000 0004", seen, rd_data, lo);
    else n_pass++;
    mfhi_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    int dones;
    bit rose;
    lat = 12;
    issue(16'h1234, 16'h0002);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({busy, bus.booth_start, hi, lo, bus.booth_a} !== 50'h0)
      $display("FAIL rstmid_async: busy=%b hi=%h lo=%h a=%h expected all 0",
               busy, hi, lo, bus.booth_a);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    rose = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done === 1'b1) dones++;
      if (bus.booth_ready === 1'b1) rose = 1'b1;
    end
    n_chk++;
    if (!rose || dones != 0 || {hi, lo} !== 32'h0)
      $display("FAIL rstmid_ignore: ready_seen=%b dones=%0d hi:lo=%h expected 1 0 00000000",
               rose, dones, {hi, lo});
    else n_pass++;
  endtask

  task automatic test_timeout_boundary;
    int cyc;
    bit seen;
    lat = TO - 1;
    issue(16'h0011, 16'h0011);
    wait_done(cyc, seen);
    n_chk++;
    if (!seen || err !== 1'b0 || lo !== 16'h0121)
      $display("FAIL to_boundary: done=%b err=%b lo=%h expected 1 0 0121", seen, err, lo);
    else n_pass++;
    tick();
  endtask

  task automatic test_timeout;
    int err_at, dones, cyc;
    bit seen;
    model_en = 1'b0;
    err_at = -1;
    dones = 0;
    issue(16'd5, 16'd5);
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (done === 1'b1) dones++;
      if (err === 1'b1) begin
        err_at = c;
        break;
      end
    end
    n_chk++;
    if (err_at != TO + 1 || dones != 0)
      $display("FAIL timeout_when: err at %0d dones=%0d expected %0d 0", err_at, dones, TO + 1);
    else n_pass++;
    n_chk++;
    if ({hi, lo} !== 32'h0000_0121 || busy !== 1'b0)
      $display("FAIL timeout_keep: hi:lo=%h busy=%b expected 00000121 0", {hi, lo}, busy);
    else n_pass++;
    model_en = 1'b1;
    lat = 3;
    tick();
    issue(16'd6, 16'd7);
    wait_done(cyc, seen);
    n_chk++;
    if (!seen || lo !== 16'd42 || err !== 1'b1)
      $display("FAIL timeout_recover: done=%b lo=%h err=%b expected 1 002a 1", seen, lo, err);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_back_to_back();
    test_mflo_stall();
    test_idle_read();
    test_reset_mid();
    test_timeout_boundary();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end
endmodule
